tx_scheduler: RTL and testbench
===============================

TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 4, giving the cycle limit in WAIT_ACC before the load is abandoned.
REQ-002 The module SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 The module SHALL have ports req0 and req1  input  1 each  requester byte-valid, held until granted.
REQ-005 The module SHALL have ports data0 and data1  input  8 each  requester bytes, held stable while the matching reqN=1.
REQ-006 The module SHALL have ports gnt0 and gnt1  output  1 each  one-cycle byte-accepted pulses.
REQ-007 The module SHALL have port tbr  input  1  transmitter buffer-ready (1 = idle and able to accept a byte).
REQ-008 The module SHALL have port iocs  output  1  transmitter chip select (0 holds the transmitter in reset).
REQ-009 The module SHALL have ports iorw  output  1 (0 = write) and ioaddr  output  2  transmitter bus control.
REQ-010 The module SHALL have port databus  output  8  byte presented to the transmitter.
REQ-011 The module SHALL have port busy  output  1  1 in any state other than IDLE.
REQ-012 The module SHALL have port err  output  1  sticky timeout flag.

Function
REQ-013 The scheduler SHALL implement states IDLE, LOAD, WAIT_ACC and WAIT_DONE, held in registered state.
REQ-014 In IDLE, when tbr=1 and (req0|req1)=1, the scheduler SHALL do all of the following in one cycle: select a winner, latch the winner's data into an 8-bit hold register, pulse the winner's gntN for exactly that cycle, and go to LOAD.
REQ-015 In IDLE, when tbr=0 or no request is present, the scheduler SHALL remain in IDLE with no grant.
REQ-016 Arbitration SHALL be round-robin: with both requests asserted, the requester not granted last wins; a single request wins unconditionally.
REQ-017 The last-granted register SHALL update only on a grant; its reset value SHALL be 1, so req0 wins the first tie.
REQ-018 At most one gntN SHALL be 1 in any cycle.
REQ-019 In LOAD, for exactly one cycle, the scheduler SHALL drive iorw=0, ioaddr=2'b00 and databus=hold register, then go to WAIT_ACC.
REQ-020 In every state other than LOAD, the scheduler SHALL drive iorw=1 and ioaddr=2'b00.
REQ-021 databus SHALL always reflect the hold register.
REQ-022 In WAIT_ACC, the scheduler SHALL count cycles from 0 and go to WAIT_DONE on the first cycle tbr=0.
REQ-023 If the WAIT_ACC count reaches TIMEOUT with tbr still 1, the scheduler SHALL set err=1 and return to IDLE; the byte SHALL be dropped and not re-granted.
REQ-024 In WAIT_DONE, the scheduler SHALL go to IDLE on the first cycle tbr=1.
REQ-025 No grant SHALL occur in the cycle WAIT_DONE exits, so the earliest next grant is one cycle after the return to IDLE.
REQ-026 iocs SHALL be 1 in all states after the first clock edge following reset deassertion.
REQ-027 err SHALL clear only on reset.
REQ-028 A reqN deasserted before its grant SHALL be ignored without error.
REQ-029 A request arriving in any non-IDLE state SHALL wait in its requester until IDLE.
REQ-030 Grant-to-load latency SHALL be 1 cycle: LOAD is the cycle after the grant.
REQ-031 The WAIT_ACC counter SHALL be wide enough to hold TIMEOUT and SHALL reset to 0 on entry to WAIT_ACC.

Reset
REQ-032 While rst=0, the scheduler SHALL asynchronously force state=IDLE, iocs=0, iorw=1, ioaddr=0, gnt0=gnt1=0, busy=0, err=0, hold register=8'h00, last-granted=1 and WAIT_ACC counter=0.
REQ-033 Reset asserted mid-transfer SHALL abandon the transfer with no gnt pulse, and iocs=0 SHALL also reset the transmitter.

Verification
REQ-034 Scenario: rst low then high, tbr=1, req0=1 with data0=8'hA5 -> gnt0 pulses one cycle, then the next cycle shows iorw=0, ioaddr=0, databus=8'hA5.
REQ-035 Scenario: req0=req1=1 continuously, tbr model drops 1 cycle after the write and rises 20 cycles later -> grants alternate 0,1,0,1 and no two grants fall within 22 cycles.
REQ-036 Scenario: tbr held 1 after LOAD with TIMEOUT=4 -> err=1 four cycles after entering WAIT_ACC, state returns to IDLE, and err stays 1 through later transfers.
REQ-037 Scenario: tbr=0 in IDLE with req1=1 -> no gnt1 until tbr=1, then gnt1 in that same cycle.
REQ-038 Scenario: rst pulsed low during WAIT_DONE -> iocs=0 and busy=0 immediately, no gnt, and the req0 tie priority is restored.

Source files
------------

// File: rtl/tx_scheduler.sv
// Two-requester round-robin byte scheduler feeding a transmitter with a
// buffer-ready handshake; times out and flags err if the write is never taken.
module tx_scheduler #(
    parameter int TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    output logic [7:0] databus,
    output logic       busy,
    output logic       err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACC, WAIT_DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    hold_q;
    logic          last_q;
    logic          iocs_q;
    logic          iorw_q;
    logic          busy_q;
    logic          err_q;

    logic          grant_d;
    logic          win_d;

    // win_d = 1 selects requester 1; on a tie the one not granted last wins
    always_comb begin
        grant_d = (state_q == IDLE) && tbr && (req0 || req1);
        win_d   = (req0 && req1) ? ~last_q : req1;
    end

    // Grants are combinational so a request is accepted in the same cycle tbr rises
    assign gnt0    = rst & grant_d & ~win_d;
    assign gnt1    = rst & grant_d & win_d;
    assign iocs    = iocs_q;
    assign iorw    = iorw_q;
    assign ioaddr  = 2'b00;
    assign databus = hold_q;
    assign busy    = busy_q;
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= 8'h00;
            last_q  <= 1'b1;
            iocs_q  <= 1'b0;
            iorw_q  <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            iocs_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        hold_q  <= win_d ? data1 : data0;
                        last_q  <= win_d;
                        state_q <= LOAD;
                        iorw_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    state_q <= WAIT_ACC;
                    iorw_q  <= 1'b1;
                    cnt_q   <= '0;
                end
                WAIT_ACC: begin
                    if (!tbr) begin
                        state_q <= WAIT_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        // Transmitter never took the byte: drop it and flag
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (tbr) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    iorw_q  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_scheduler.sv
// Self-checking bench for tx_scheduler: directed scenarios plus randomized
// traffic compared each cycle against a transaction-level reference model.
module tb_tx_scheduler;

    localparam int TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       tbr = 1'b0;
    logic       gnt0, gnt1, iocs, iorw, busy, err;
    logic [1:0] ioaddr;
    logic [7:0] databus;

    int checks = 0;
    int failures = 0;

    // Reference model: phase 0 idle, 1 write, 2 awaiting acceptance, 3 awaiting done
    int         m_phase;
    int         m_wait;
    int         m_last;
    logic [7:0] m_hold;
    logic       m_err;
    logic       m_cs;

    tx_scheduler #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .tbr(tbr),
        .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_wait  = 0;
        m_last  = 1;
        m_hold  = 8'h00;
        m_err   = 1'b0;
        m_cs    = 1'b0;
    endtask

    // Assert reset at a falling edge, verify the asynchronous effect, release one cycle later
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_iocs", iocs, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_err", err, 0);
        chk("rst_iorw", iorw, 1);
        chk("rst_databus", databus, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: drive at the falling edge, check, advance model at the rising edge
    task automatic step(input logic t, input logic a0, input logic [7:0] x0,
                        input logic a1, input logic [7:0] x1,
                        output logic og0, output logic og1, output logic owr);
        int  winner;
        bit  exp_grant;
        tbr = t; req0 = a0; data0 = x0; req1 = a1; data1 = x1;
        #1;
        exp_grant = (m_phase == 0) && t && (a0 || a1);
        if (a0 && a1) winner = (m_last == 1) ? 0 : 1;
        else          winner = a0 ? 0 : 1;
        chk("gnt0", gnt0, exp_grant && winner == 0);
        chk("gnt1", gnt1, exp_grant && winner == 1);
        chk("iorw", iorw, m_phase != 1);
        chk("ioaddr", ioaddr, 0);
        chk("databus", databus, m_hold);
        chk("busy", busy, m_phase != 0);
        chk("err", err, m_err);
        chk("iocs", iocs, m_cs);
        og0 = gnt0; og1 = gnt1; owr = !iorw;
        @(posedge clk);
        m_cs = 1'b1;
        if (m_phase == 0) begin
            if (exp_grant) begin
                m_hold  = winner ? x1 : x0;
                m_last  = winner;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
            m_wait  = 0;
        end else if (m_phase == 2) begin
            if (!t) m_phase = 3;
            else begin
                m_wait++;
                if (m_wait >= TIMEOUT) begin
                    m_err   = 1'b1;
                    m_phase = 0;
                end
            end
        end else begin
            if (t) m_phase = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        logic g0, g1, wr;
        logic r0, r1;
        logic [7:0] v0, v1;
        int   cyc, wr_cyc, ngr, prev_w, prev_c;
        logic tb;

        model_reset();
        @(negedge clk);
        do_reset();

        // Basic single-request transfer
        step(1, 1, 8'hA5, 0, 8'h00, g0, g1, wr);
        chk("sc1_gnt0", g0, 1);
        step(1, 0, 8'h00, 0, 8'h00, g0, g1, wr);
        chk("sc1_write", wr, 1);
        chk("sc1_data", databus, 8'hA5);
        step(0, 0, 8'h00, 0, 8'h00, g0, g1, wr);
        step(1, 0, 8'h00, 0, 8'h00, g0, g1, wr);

        // Reset during WAIT_DONE restores tie priority to requester 0
        step(1, 1, 8'h11, 0, 8'h00, g0, g1, wr);
        step(1, 0, 8'h00, 0, 8'h00, g0, g1, wr);
        step(0, 0, 8'h00, 0, 8'h00, g0, g1, wr);
        step(0, 0, 8'h00, 0, 8'h00, g0, g1, wr);
        chk("sc5_in_done_busy", busy, 1);
        tbr = 1'b1; req0 = 1'b1; req1 = 1'b1;
        do_reset();
        step(1, 1, 8'h33, 1, 8'h44, g0, g1, wr);
        chk("sc5_tie_gnt0", g0, 1);
        chk("sc5_tie_gnt1", g1, 0);
        step(1, 0, 8'h00, 1, 8'h44, g0, g1, wr);
        chk("sc5_data", databus, 8'h33);
        step(0, 0, 8'h00, 1, 8'h44, g0, g1, wr);
        step(1, 0, 8'h00, 1, 8'h44, g0, g1, wr);

        // tbr low in IDLE holds off the grant; granted the cycle tbr rises
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 8'h00, 1, 8'h55, g0, g1, wr);
            chk("sc4_hold_gnt1", g1, 0);
        end
        step(1, 0, 8'h00, 1, 8'h55, g0, g1, wr);
        chk("sc4_gnt1", g1, 1);
        step(1, 0, 8'h00, 0, 8'h00, g0, g1, wr);

        // Timeout: tbr stays high through WAIT_ACC
        for (int i = 0; i < TIMEOUT; i++) begin
            chk("sc3_err_pre", err, 0);
            step(1, 0, 8'h00, 0, 8'h00, g0, g1, wr);
        end
        chk("sc3_err", err, 1);
        chk("sc3_idle", busy, 0);
        step(1, 1, 8'h66, 0, 8'h00, g0, g1, wr);
        chk("sc3_regrant", g0, 1);
        step(1, 0, 8'h00, 0, 8'h00, g0, g1, wr);
        step(0, 0, 8'h00, 0, 8'h00, g0, g1, wr);
        step(1, 0, 8'h00, 0, 8'h00, g0, g1, wr);
        chk("sc3_err_sticky", err, 1);

        // Continuous contention with a slow transmitter
        do_reset();
        wr_cyc = -100; ngr = 0; prev_w = -1; prev_c = -1000;
        for (cyc = 0; cyc < 120; cyc++) begin
            tb = !(cyc >= wr_cyc + 1 && cyc <= wr_cyc + 20);
            step(tb, 1, 8'hC0, 1, 8'hC1, g0, g1, wr);
            if (wr) wr_cyc = cyc;
            if (g0 || g1) begin
                if (prev_w >= 0) begin
                    chk("sc2_alternate", g1, prev_w == 0);
                    chk("sc2_spacing", (cyc - prev_c) > 22, 1);
                end
                prev_w = g1 ? 1 : 0;
                prev_c = cyc;
                ngr++;
            end
        end
        chk("sc2_grant_count", ngr >= 4, 1);

        // Randomized traffic with occasional resets and request withdrawal
        do_reset();
        r0 = 0; r1 = 0; v0 = 8'h00; v1 = 8'h00;
        for (cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            if (!r0 && $urandom_range(0, 2) == 0) begin r0 = 1; v0 = 8'($urandom); end
            else if (r0 && $urandom_range(0, 19) == 0) r0 = 0;
            if (!r1 && $urandom_range(0, 2) == 0) begin r1 = 1; v1 = 8'($urandom); end
            else if (r1 && $urandom_range(0, 19) == 0) r1 = 0;
            tb = ($urandom_range(0, 2) != 0);
            step(tb, r0, v0, r1, v1, g0, g1, wr);
            chk("rand_onehot", g0 & g1, 0);
            if (g0) r0 = 0;
            if (g1) r1 = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
